// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the flexible FIFO.
// Imported by the FIFO top and its storage sub-module.
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int fifo_cw(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// DATA_WIDTH x DEPTH register array for the FIFO.
// Synchronous write port, combinational read port, no reset.
module fifo_regfile
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = fifo_cw(DEPTH - 1)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // store the incoming word at the write pointer
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO: any depth, standard or FWFT read,
// thresholds, occupancy count and sticky error flags.
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = FIFO_MODE_STD,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int CW         = fifo_cw(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int PW = fifo_cw(DEPTH - 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_flex: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_sync_flex: AF_THRESH out of 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_flex: AE_THRESH out of 0..DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] rdata;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  // a full FIFO still takes a write when a read frees a slot
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  fifo_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_regfile (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // pointers advance on accept and wrap explicitly at DEPTH-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (rd_acc)
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
    end
  end

  // occupancy tracks net accepted writes minus reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // sticky error flags; a new event beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en & ~wr_acc)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
      if (rd_en & ~rd_acc)
        underflow <= 1'b1;
      else if (clr_err)
        underflow <= 1'b0;
    end
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign dout = rdata;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;

    // head word is captured on an accepted read, held otherwise
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        dout_q <= '0;
      else if (rd_acc)
        dout_q <= rdata;
    end

    assign dout = dout_q;
  end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Scoreboard bench: standard and FWFT FIFOs, DEPTH=5,
// driven in lockstep with directed vectors.
module tb_fifo_sync_flex;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din = '0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] s_dout, f_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] s_count, f_count;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q_exp [$];
  logic       rd_strobe = 1'b0;
  logic       pend;

  always #5 clk = ~clk;

  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(s_dout), .full(s_full),
    .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf), .clr_err(clr_err)
  );

  fifo_sync_flex #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .dout(f_dout), .full(f_full),
    .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf), .clr_err(clr_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // drive one cycle of stimulus at a negedge, return at the next negedge
  task automatic op(input logic w, input logic [7:0] d,
                    input logic r, input logic ex,
                    input logic [7:0] ed);
    wr_en = w;
    din = d;
    rd_en = r;
    rd_strobe = ex;
    if (ex) q_exp.push_back(ed);
    @(negedge clk);
  endtask

  task automatic idle();
    op(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  // a read issued this cycle has its data on s_dout after the edge
  always @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else pend <= rd_strobe;
  end

  // monitor: compare standard-mode dout against the expected queue
  always @(negedge clk) begin
    if (pend) begin
      vectors++;
      if (q_exp.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underrun: got %0h want none", s_dout);
      end else begin
        logic [7:0] e;
        e = q_exp.pop_front();
        if (s_dout !== e) begin
          miscompares++;
          $display("FAIL sb_dout: got %0h want %0h at %0t", s_dout, e, $time);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_count", int'(s_count), 0);
    chk("rst_empty", int'(s_empty), 1);
    chk("rst_full", int'(s_full), 0);
    chk("rst_af", int'(s_af), 0);
    chk("rst_ae", int'(s_ae), 1);
    chk("rst_dout", int'(s_dout), 0);
    chk("rst_ovf", int'(s_ovf), 0);
    chk("rst_unf", int'(s_unf), 0);

    // fill, overflow, drain
    for (int i = 1; i <= 5; i++) begin
      op(1'b1, 8'(8'h11 * i), 1'b0, 1'b0, 8'h00);
      chk("fill_count", int'(s_count), i);
      chk("fill_af", int'(s_af), (i >= 3) ? 1 : 0);
      chk("fill_ae", int'(s_ae), (i <= 2) ? 1 : 0);
    end
    chk("fill_full", int'(s_full), 1);
    op(1'b1, 8'h66, 1'b0, 1'b0, 8'h00);
    chk("ovf_set", int'(s_ovf), 1);
    chk("ovf_count", int'(s_count), 5);
    for (int i = 1; i <= 5; i++)
      op(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h11 * i));
    chk("drain_empty", int'(s_empty), 1);
    chk("drain_count", int'(s_count), 0);
    chk("ovf_sticky", int'(s_ovf), 1);
    clr_err = 1'b1;
    idle();
    clr_err = 1'b0;
    chk("ovf_clr", int'(s_ovf), 0);

    // wrap-around over several pointer laps
    for (int i = 0; i < 12; i++) begin
      op(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
      chk("wrap_cnt1", int'(s_count), 1);
      op(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
      chk("wrap_cnt0", int'(s_count), 0);
    end

    // simultaneous write and read on full, then on empty
    for (int i = 1; i <= 5; i++)
      op(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
    op(1'b1, 8'hAA, 1'b1, 1'b1, 8'h01);
    chk("fullrw_count", int'(s_count), 5);
    chk("fullrw_ovf", int'(s_ovf), 0);
    for (int i = 2; i <= 5; i++)
      op(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
    op(1'b0, 8'h00, 1'b1, 1'b1, 8'hAA);
    chk("fullrw_empty", int'(s_empty), 1);
    op(1'b1, 8'h5A, 1'b1, 1'b0, 8'h00);
    chk("emptyrw_count", int'(s_count), 1);
    chk("emptyrw_unf", int'(s_unf), 1);
    op(1'b0, 8'h00, 1'b1, 1'b1, 8'h5A);
    chk("emptyrw_drain", int'(s_count), 0);

    // underflow stickiness, clear collision, rejected read holds dout
    op(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("unf_set", int'(s_unf), 1);
    chk("unf_dout_hold", int'(s_dout), 8'h5A);
    chk("unf_count", int'(s_count), 0);
    idle();
    chk("unf_persist", int'(s_unf), 1);
    clr_err = 1'b1;
    op(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("unf_set_wins", int'(s_unf), 1);
    idle();
    clr_err = 1'b0;
    chk("unf_clr", int'(s_unf), 0);

    // first-word-fall-through behaviour
    op(1'b1, 8'h3C, 1'b0, 1'b0, 8'h00);
    chk("fw_empty0", int'(f_empty), 0);
    chk("fw_dout", int'(f_dout), 8'h3C);
    chk("fw_count1", int'(f_count), 1);
    idle();
    chk("fw_hold", int'(f_dout), 8'h3C);
    op(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("fw_empty1", int'(f_empty), 1);
    chk("fw_count0", int'(f_count), 0);
    op(1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    op(1'b1, 8'h42, 1'b0, 1'b0, 8'h00);
    chk("fw_head", int'(f_dout), 8'h41);
    op(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("fw_next", int'(f_dout), 8'h42);
    op(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("fw_drain", int'(f_empty), 1);

    // asynchronous reset in the middle of a burst
    op(1'b1, 8'h01, 1'b0, 1'b0, 8'h00);
    op(1'b1, 8'h02, 1'b0, 1'b0, 8'h00);
    op(1'b1, 8'h03, 1'b0, 1'b0, 8'h00);
    chk("pre_rst_count", int'(s_count), 3);
    wr_en = 1'b1;
    din = 8'h04;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", int'(s_count), 0);
    chk("arst_empty", int'(s_empty), 1);
    chk("arst_dout", int'(s_dout), 0);
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    op(1'b1, 8'h7E, 1'b0, 1'b0, 8'h00);
    chk("post_rst_count", int'(s_count), 1);
    chk("post_rst_fw", int'(f_dout), 8'h7E);
    op(1'b0, 8'h00, 1'b1, 1'b1, 8'h7E);
    idle();
    chk("post_rst_empty", int'(s_empty), 1);

    chk("sb_leftover", q_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
